mult_issue_sched: RTL and testbench

Issue scheduler for the pipelined multiplier functional unit. Arbitrates among NUM_REQ multiply-ready reservation-station slots each cycle, selecting the oldest by ROB age relative to the ROB head. Registers the winning operation into an issue stage that drives the multiplier's operand, ROB-tag and physical-destination inputs. Tracks in-flight operations through the multiplier's two-stage pipe and squashes all state on mispredict.

---
 rtl/mult_issue_sched_pkg.sv | 40 ++++
 rtl/mult_issue_sched_if.sv | 46 ++++
 rtl/mult_issue_sched_age_select.sv | 58 +++++
 rtl/mult_issue_sched.sv | 86 ++++++++
 tb/tb_mult_issue_sched.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mult_issue_sched_pkg.sv
// ---------------------------------------------------------------------------
// mult_issue_sched_pkg
// Shared types for the multiply and ALU issue schedulers.
//   WORD_SIZE_P, ROB_ENTRY, NUM_PHYS_REG : datapath and tag-space sizes
//   rob_tag_t / preg_tag_t / word_t      : tag and operand types
//   issue_pkt_t                          : one issued operation
//   rob_age()                            : distance of a tag from the ROB head
//   popcount3()                          : valid count of a 3-deep shadow pipe
// ---------------------------------------------------------------------------
package mult_issue_sched_pkg;

   localparam int WORD_SIZE_P  = 16;
   localparam int ROB_ENTRY    = 16;   // power of two
   localparam int NUM_PHYS_REG = 32;
   localparam int ROB_W        = $clog2(ROB_ENTRY);
   localparam int PR_W         = $clog2(NUM_PHYS_REG);

   typedef logic [ROB_W-1:0]       rob_tag_t;
   typedef logic [PR_W-1:0]        preg_tag_t;
   typedef logic [WORD_SIZE_P-1:0] word_t;

   typedef struct packed {
      logic      valid;
      word_t     op1;
      word_t     op2;
      rob_tag_t  rob_dest;
      preg_tag_t reg_dest;
   } issue_pkt_t;

   // Subtraction in ROB_W bits gives the modulo distance, so a tag that has
   // wrapped past the end of the ROB still reads as younger than the head.
   function automatic rob_tag_t rob_age(input rob_tag_t tag, input rob_tag_t head);
      return rob_tag_t'(tag - head);
   endfunction

   function automatic logic [1:0] popcount3(input logic [2:0] v);
      return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
   endfunction

endpackage

// File: rtl/mult_issue_sched_if.sv
// ---------------------------------------------------------------------------
// mult_issue_sched_if
// Bundle between the reservation station / ROB side and the multiply issue
// scheduler.
//   master : drives requests, ROB head, hold and mispredict; sees grant and
//            the registered issue packet
//   slave  : the scheduler itself
// ---------------------------------------------------------------------------
interface mult_issue_sched_if #(
   parameter int NUM_REQ = 4
) ();
   import mult_issue_sched_pkg::*;

   logic      [NUM_REQ-1:0] req_v_i;
   word_t     [NUM_REQ-1:0] req_op1_i;
   word_t     [NUM_REQ-1:0] req_op2_i;
   rob_tag_t  [NUM_REQ-1:0] req_rob_i;
   preg_tag_t [NUM_REQ-1:0] req_reg_i;
   rob_tag_t                rob_head_i;
   logic                    issue_hold_i;
   logic                    mispredict_i;

   logic      [NUM_REQ-1:0] gnt_o;
   logic                    exe_v_o;
   word_t                   operand1_o;
   word_t                   operand2_o;
   rob_tag_t                rob_dest_o;
   preg_tag_t               reg_dest_o;
   logic      [1:0]         inflight_o;
   logic                    idle_o;

   modport master (
      output req_v_i, req_op1_i, req_op2_i, req_rob_i, req_reg_i,
             rob_head_i, issue_hold_i, mispredict_i,
      input  gnt_o, exe_v_o, operand1_o, operand2_o, rob_dest_o,
             reg_dest_o, inflight_o, idle_o
   );

   modport slave (
      input  req_v_i, req_op1_i, req_op2_i, req_rob_i, req_reg_i,
             rob_head_i, issue_hold_i, mispredict_i,
      output gnt_o, exe_v_o, operand1_o, operand2_o, rob_dest_o,
             reg_dest_o, inflight_o, idle_o
   );

endinterface

// File: rtl/mult_issue_sched_age_select.sv
// ---------------------------------------------------------------------------
// mult_issue_sched_age_select
// Oldest-first selector over NUM_REQ slots, purely combinational.
//   req_v    : slot valid mask
//   req_rob  : ROB tag per slot
//   rob_head : current ROB head
//   gnt      : one-hot winner (zero when no slot is valid)
// Smallest distance from the head wins; equal ages go to the lowest index.
// ---------------------------------------------------------------------------
module mult_issue_sched_age_select
   import mult_issue_sched_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic     [NUM_REQ-1:0] req_v,
   input  rob_tag_t [NUM_REQ-1:0] req_rob,
   input  rob_tag_t               rob_head,
   output logic     [NUM_REQ-1:0] gnt
);

   localparam int IDX_W = $clog2(NUM_REQ);

   rob_tag_t [NUM_REQ-1:0] age;

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_age
         assign age[gi] = rob_age(req_rob[gi], rob_head);
      end
   endgenerate

   logic             found;
   rob_tag_t         best_age;
   logic [IDX_W-1:0] best_idx;

   // Linear scan with a strict compare: a later slot only displaces the
   // current best when it is strictly older, which gives the low-index tie
   // break for free.
   always_comb begin
      found    = 1'b0;
      best_age = '0;
      best_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (req_v[i] && (!found || (age[i] < best_age))) begin
            found    = 1'b1;
            best_age = age[i];
            best_idx = IDX_W'(i);
         end
      end
   end

   always_comb begin
      gnt = '0;
      if (found) begin
         gnt[best_idx] = 1'b1;
      end
   end

endmodule

// File: rtl/mult_issue_sched.sv
// ---------------------------------------------------------------------------
// mult_issue_sched
// Issue scheduler for the two-stage pipelined multiplier.
//   clk_i      : clock, rising edge
//   reset_n_i  : asynchronous active-low reset
//   bus        : request slots, ROB head, hold/mispredict in; one-hot grant,
//                registered issue packet, in-flight count and idle out
// Each cycle the oldest ready slot (by ROB distance from head) is granted
// combinationally and its fields are captured into the issue register on the
// same edge the slot frees itself. A shadow valid pipe follows the op through
// the multiplier's two stages so inflight_o counts issue + both stages.
// ---------------------------------------------------------------------------
module mult_issue_sched
   import mult_issue_sched_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic             clk_i,
   input  logic             reset_n_i,
   mult_issue_sched_if.slave bus
);

   logic [NUM_REQ-1:0] sel_gnt;
   logic [NUM_REQ-1:0] gnt;
   logic               kill;

   issue_pkt_t issue_reg;
   issue_pkt_t issue_next;
   logic [2:1] stage_reg;     // mirrors the multiplier's own stage valids
   logic [2:1] stage_next;

   mult_issue_sched_age_select #(
      .NUM_REQ (NUM_REQ)
   ) u_age_select (
      .req_v    (bus.req_v_i),
      .req_rob  (bus.req_rob_i),
      .rob_head (bus.rob_head_i),
      .gnt      (sel_gnt)
   );

   // Hold and mispredict both suppress the grant; a mispredict additionally
   // clears the shadow pipe below.
   assign kill = bus.issue_hold_i | bus.mispredict_i;
   assign gnt  = kill ? '0 : sel_gnt;

   // Data fields hold when nothing is granted; only valid tracks the grant.
   always_comb begin
      issue_next       = issue_reg;
      issue_next.valid = |gnt;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt[i]) begin
            issue_next.op1      = bus.req_op1_i[i];
            issue_next.op2      = bus.req_op2_i[i];
            issue_next.rob_dest = bus.req_rob_i[i];
            issue_next.reg_dest = bus.req_reg_i[i];
         end
      end
   end

   always_comb begin
      stage_next = {stage_reg[1], issue_reg.valid};
      if (bus.mispredict_i) begin
         stage_next = '0;
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         issue_reg <= '0;
         stage_reg <= '0;
      end else begin
         issue_reg <= issue_next;
         stage_reg <= stage_next;
      end
   end

   assign bus.gnt_o      = gnt;
   assign bus.exe_v_o    = issue_reg.valid;
   assign bus.operand1_o = issue_reg.op1;
   assign bus.operand2_o = issue_reg.op2;
   assign bus.rob_dest_o = issue_reg.rob_dest;
   assign bus.reg_dest_o = issue_reg.reg_dest;
   assign bus.inflight_o = popcount3({stage_reg, issue_reg.valid});
   assign bus.idle_o     = (bus.inflight_o == 2'd0) && !(|bus.req_v_i);

endmodule

// File: tb/tb_mult_issue_sched.sv
// ---------------------------------------------------------------------------
// tb_mult_issue_sched
// Directed scenarios followed by constrained-random traffic, all checked
// against a behavioural model: grant = slot with the smallest
// (tag - head) mod ROB_ENTRY, lowest index on ties; issue register and a
// three-entry history of issue valids model the multiplier pipe.
// ---------------------------------------------------------------------------
module tb_mult_issue_sched;
   import mult_issue_sched_pkg::*;

   localparam int N = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mult_issue_sched_if #(.NUM_REQ(N)) bus ();

   mult_issue_sched #(.NUM_REQ(N)) dut (
      .clk_i     (clk),
      .reset_n_i (rst_n),
      .bus       (bus)
   );

   int errors = 0;
   int checks = 0;

   // model state
   bit        m_exe_v;
   int        m_op1, m_op2, m_rob, m_reg;
   bit [2:0]  m_hist;          // [0]=issue reg, [1],[2]=multiplier stages
   int        last_g;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int ref_gnt();
      int best, best_age, a;
      best = -1;
      best_age = 0;
      if (bus.issue_hold_i || bus.mispredict_i) return 0;
      for (int i = 0; i < N; i++) begin
         if (bus.req_v_i[i]) begin
            a = (int'(bus.req_rob_i[i]) + ROB_ENTRY - int'(bus.rob_head_i)) % ROB_ENTRY;
            if (best < 0 || a < best_age) begin
               best = i;
               best_age = a;
            end
         end
      end
      return (best < 0) ? 0 : (1 << best);
   endfunction

   function automatic int pop3(input bit [2:0] v);
      return int'(v[0]) + int'(v[1]) + int'(v[2]);
   endfunction

   task automatic model_reset();
      m_exe_v = 0; m_op1 = 0; m_op2 = 0; m_rob = 0; m_reg = 0;
      m_hist = '0; last_g = 0;
   endtask

   task automatic drive_idle();
      bus.req_v_i = '0;
      bus.req_op1_i = '0;
      bus.req_op2_i = '0;
      bus.req_rob_i = '0;
      bus.req_reg_i = '0;
      bus.rob_head_i = '0;
      bus.issue_hold_i = 1'b0;
      bus.mispredict_i = 1'b0;
   endtask

   // Check all outputs against the model at the falling edge, then advance
   // the model across the rising edge; returns with inputs free to change.
   task automatic cycle();
      int g, idx;
      bit [2:0] h_next;
      @(negedge clk);
      g = ref_gnt();
      check("gnt", int'(bus.gnt_o), g);
      check("exe_v", int'(bus.exe_v_o), int'(m_exe_v));
      check("op1", int'(bus.operand1_o), m_op1);
      check("op2", int'(bus.operand2_o), m_op2);
      check("rob_dest", int'(bus.rob_dest_o), m_rob);
      check("reg_dest", int'(bus.reg_dest_o), m_reg);
      check("inflight", int'(bus.inflight_o), pop3(m_hist));
      check("idle", int'(bus.idle_o), int'(pop3(m_hist) == 0 && bus.req_v_i == '0));
      idx = -1;
      for (int i = 0; i < N; i++) if (g == (1 << i)) idx = i;
      h_next = bus.mispredict_i ? 3'b000 : {m_hist[1:0], (g != 0)};
      if (idx >= 0) begin
         m_op1 = int'(bus.req_op1_i[idx]);
         m_op2 = int'(bus.req_op2_i[idx]);
         m_rob = int'(bus.req_rob_i[idx]);
         m_reg = int'(bus.req_reg_i[idx]);
      end
      @(posedge clk);
      m_hist  = h_next;
      m_exe_v = h_next[0];
      last_g  = g;
      #1;
   endtask

   task automatic set_slot(input int i, input int tag, input int o1, input int o2, input int r);
      bus.req_v_i[i]   = 1'b1;
      bus.req_rob_i[i] = rob_tag_t'(tag);
      bus.req_op1_i[i] = word_t'(o1);
      bus.req_op2_i[i] = word_t'(o2);
      bus.req_reg_i[i] = preg_tag_t'(r);
   endtask

   initial begin
      drive_idle();
      model_reset();
      rst_n = 1'b0;
      #12;
      check("rst_exe_v", int'(bus.exe_v_o), 0);
      check("rst_inflight", int'(bus.inflight_o), 0);
      check("rst_rob_dest", int'(bus.rob_dest_o), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      cycle();

      // oldest-first
      bus.rob_head_i = 4'd3;
      set_slot(0, 5, 1, 2, 10);
      set_slot(1, 4, 3, 4, 11);
      set_slot(2, 9, 5, 6, 12);
      set_slot(3, 7, 7, 8, 13);
      #1 check("oldest_gnt", int'(bus.gnt_o), 4'b0010);
      cycle();
      drive_idle();
      #1;
      check("oldest_rob_dest", int'(bus.rob_dest_o), 4);
      check("oldest_exe_v", int'(bus.exe_v_o), 1);
      cycle();

      // wrap-around
      bus.rob_head_i = 4'd14;
      set_slot(0, 1, 0, 0, 1);
      set_slot(1, 15, 0, 0, 2);
      set_slot(2, 14, 0, 0, 3);
      set_slot(3, 2, 0, 0, 4);
      #1 check("wrap_gnt", int'(bus.gnt_o), 4'b0100);
      cycle();
      drive_idle();

      // tie
      bus.rob_head_i = 4'd2;
      set_slot(1, 6, 0, 0, 5);
      set_slot(3, 6, 0, 0, 6);
      #1 check("tie_gnt", int'(bus.gnt_o), 4'b0010);
      cycle();
      drive_idle();
      repeat (3) cycle();

      // back-to-back: one new request per cycle, then drain
      for (int k = 0; k < 4; k++) begin
         drive_idle();
         set_slot(k, k, 7, 9, k + 20);
         cycle();
         check("b2b_inflight", int'(bus.inflight_o), (k < 3) ? k + 1 : 3);
         check("b2b_op1", int'(bus.operand1_o), 7);
         check("b2b_op2", int'(bus.operand2_o), 9);
      end
      drive_idle();
      for (int k = 0; k < 3; k++) begin
         cycle();
         check("drain_inflight", int'(bus.inflight_o), 2 - k);
      end

      // hold
      set_slot(0, 1, 0, 0, 0);
      bus.issue_hold_i = 1'b1;
      #1 check("hold_gnt", int'(bus.gnt_o), 0);
      cycle();
      drive_idle();

      // mispredict with a full pipe and all slots requesting
      for (int k = 0; k < 3; k++) begin
         drive_idle();
         set_slot(k, k + 1, k, k, k);
         cycle();
      end
      drive_idle();
      for (int k = 0; k < N; k++) set_slot(k, k, 1, 1, 1);
      bus.mispredict_i = 1'b1;
      #1;
      check("mp_inflight_before", int'(bus.inflight_o), 3);
      check("mp_gnt", int'(bus.gnt_o), 0);
      cycle();
      drive_idle();
      #1;
      check("mp_exe_v_after", int'(bus.exe_v_o), 0);
      check("mp_inflight_after", int'(bus.inflight_o), 0);
      cycle();

      // asynchronous reset mid-stream
      set_slot(2, 5, 3, 3, 3);
      cycle();
      drive_idle();
      check("pre_rst_exe_v", int'(bus.exe_v_o), 1);
      rst_n = 1'b0;
      #1;
      check("midrst_exe_v", int'(bus.exe_v_o), 0);
      check("midrst_inflight", int'(bus.inflight_o), 0);
      check("midrst_rob_dest", int'(bus.rob_dest_o), 0);
      model_reset();
      @(posedge clk); #1;
      rst_n = 1'b1;
      #1 check("post_rst_idle", int'(bus.idle_o), 1);
      cycle();

      // random traffic; a slot granted last cycle must drop its request
      for (int n = 0; n < 400; n++) begin
         bus.rob_head_i = rob_tag_t'($urandom_range(0, ROB_ENTRY - 1));
         for (int i = 0; i < N; i++) begin
            bus.req_v_i[i]   = (last_g == (1 << i)) ? 1'b0 : 1'($urandom_range(0, 1));
            bus.req_rob_i[i] = rob_tag_t'($urandom);
            bus.req_op1_i[i] = word_t'($urandom);
            bus.req_op2_i[i] = word_t'($urandom);
            bus.req_reg_i[i] = preg_tag_t'($urandom);
         end
         bus.issue_hold_i = ($urandom_range(0, 7) == 0);
         bus.mispredict_i = ($urandom_range(0, 15) == 0);
         cycle();
      end
      drive_idle();
      repeat (4) cycle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
